// File: rtl/rdma_wr_req_sink.sv
// Memory-side sink for RoCE write requests: queues commands, issues one memory write
// per request, trims the data stream to exactly len bytes and reports a completion.
module rdma_wr_req_sink #(
    parameter int DATA_BITS  = 512,
    parameter int VADDR_BITS = 48,
    parameter int LEN_BITS   = 28,
    parameter int PID_BITS   = 6,
    parameter int VFID_BITS  = 4,
    parameter int CMD_DEPTH  = 4
) (
    input  logic                   nclk,
    input  logic                   nresetn,

    input  logic                   s_req_valid,
    output logic                   s_req_ready,
    input  logic [VADDR_BITS-1:0]  s_req_vaddr,
    input  logic [LEN_BITS-1:0]    s_req_len,
    input  logic [PID_BITS-1:0]    s_req_pid,
    input  logic [VFID_BITS-1:0]   s_req_vfid,
    input  logic                   s_req_host,

    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [DATA_BITS-1:0]   s_axis_tdata,
    input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,

    output logic                   m_cmd_valid,
    input  logic                   m_cmd_ready,
    output logic [VADDR_BITS-1:0]  m_cmd_vaddr,
    output logic [LEN_BITS-1:0]    m_cmd_len,
    output logic                   m_cmd_host,

    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,

    output logic                   m_cmpl_valid,
    input  logic                   m_cmpl_ready,
    output logic [PID_BITS-1:0]    m_cmpl_pid,
    output logic [VFID_BITS-1:0]   m_cmpl_vfid,
    output logic [LEN_BITS-1:0]    m_cmpl_len,
    output logic                   m_cmpl_err,

    output logic [31:0]            cnt_short,
    output logic [31:0]            cnt_long
);

    localparam int BYTES      = DATA_BITS / 8;
    localparam int OFF_BITS   = $clog2(BYTES);
    localparam int AW         = $clog2(CMD_DEPTH);
    localparam int CNT_W      = AW + 1;
    localparam int KEEP_CNT_W = $clog2(BYTES + 1);

    typedef enum logic [2:0] {IDLE, CMD, DATA, DRAIN, CMPL} state_t;

    function automatic logic [KEEP_CNT_W-1:0] popcount(input logic [BYTES-1:0] k);
        logic [KEEP_CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < BYTES; i++) c = c + KEEP_CNT_W'(k[i]);
        return c;
    endfunction

    // Byte-enable mask for the final beat; a zero remainder means a full beat.
    function automatic logic [BYTES-1:0] keep_mask(input logic [LEN_BITS-1:0] len);
        logic [OFF_BITS-1:0] rem;
        logic [BYTES-1:0]    m;
        rem = len[OFF_BITS-1:0];
        for (int i = 0; i < BYTES; i++) m[i] = (rem == '0) || (i < int'(rem));
        return m;
    endfunction

    logic [VADDR_BITS-1:0] fifo_vaddr [CMD_DEPTH];
    logic [LEN_BITS-1:0]   fifo_len   [CMD_DEPTH];
    logic [PID_BITS-1:0]   fifo_pid   [CMD_DEPTH];
    logic [VFID_BITS-1:0]  fifo_vfid  [CMD_DEPTH];
    logic                  fifo_host  [CMD_DEPTH];

    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count, count_nxt;
    logic                  req_ready_q;

    state_t                state;
    logic [VADDR_BITS-1:0] cur_vaddr;
    logic [LEN_BITS-1:0]   cur_len;
    logic [PID_BITS-1:0]   cur_pid;
    logic [VFID_BITS-1:0]  cur_vfid;
    logic                  cur_host;
    logic [LEN_BITS-1:0]   last_idx;
    logic [BYTES-1:0]      keep_last;
    logic [LEN_BITS-1:0]   beat_cnt;
    logic [LEN_BITS-1:0]   cmpl_len_q;
    logic                  cmpl_err_q;
    logic [31:0]           cnt_short_q, cnt_long_q;

    logic                  push, pop;
    logic                  in_data, at_last, out_hs, drain_last;
    logic [BYTES-1:0]      out_keep;

    assign push = s_req_valid && req_ready_q;
    assign pop  = (state == IDLE) && (count != '0);

    always_comb begin
        count_nxt = count;
        if (push && !pop)      count_nxt = count + CNT_W'(1);
        else if (!push && pop) count_nxt = count - CNT_W'(1);
    end

    always_ff @(posedge nclk) begin
        if (push) begin
            fifo_vaddr[wr_ptr] <= s_req_vaddr;
            fifo_len[wr_ptr]   <= s_req_len;
            fifo_pid[wr_ptr]   <= s_req_pid;
            fifo_vfid[wr_ptr]  <= s_req_vfid;
            fifo_host[wr_ptr]  <= s_req_host;
        end
    end

    // Data path is a straight pass-through while in DATA; only tkeep/tlast are shaped.
    assign in_data    = (state == DATA);
    assign at_last    = (beat_cnt == last_idx);
    assign out_keep   = at_last ? (s_axis_tkeep & keep_last) : s_axis_tkeep;
    assign out_hs     = m_axis_tvalid && m_axis_tready;
    assign drain_last = (state == DRAIN) && s_axis_tvalid && s_axis_tlast;

    assign m_axis_tvalid = in_data && s_axis_tvalid;
    assign m_axis_tdata  = in_data ? s_axis_tdata : '0;
    assign m_axis_tkeep  = in_data ? out_keep : '0;
    assign m_axis_tlast  = in_data && (at_last || s_axis_tlast);
    assign s_axis_tready = in_data ? m_axis_tready : (state == DRAIN);

    always_ff @(posedge nclk) begin
        if (!nresetn) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            req_ready_q <= 1'b0;
            cur_vaddr   <= '0;
            cur_len     <= '0;
            cur_pid     <= '0;
            cur_vfid    <= '0;
            cur_host    <= 1'b0;
            last_idx    <= '0;
            keep_last   <= '0;
            beat_cnt    <= '0;
            cmpl_len_q  <= '0;
            cmpl_err_q  <= 1'b0;
            cnt_short_q <= '0;
            cnt_long_q  <= '0;
        end else begin
            req_ready_q <= (count_nxt != CNT_W'(CMD_DEPTH));
            count       <= count_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);

            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_vaddr <= fifo_vaddr[rd_ptr];
                        cur_len   <= fifo_len[rd_ptr];
                        cur_pid   <= fifo_pid[rd_ptr];
                        cur_vfid  <= fifo_vfid[rd_ptr];
                        cur_host  <= fifo_host[rd_ptr];
                        last_idx  <= (fifo_len[rd_ptr] - LEN_BITS'(1)) >> OFF_BITS;
                        keep_last <= keep_mask(fifo_len[rd_ptr]);
                        beat_cnt  <= '0;
                        if (fifo_len[rd_ptr] == '0) begin
                            cmpl_len_q <= '0;
                            cmpl_err_q <= 1'b0;
                            state      <= CMPL;
                        end else begin
                            state <= CMD;
                        end
                    end
                end
                CMD: begin
                    if (m_cmd_ready) state <= DATA;
                end
                DATA: begin
                    if (out_hs) begin
                        beat_cnt   <= beat_cnt + LEN_BITS'(1);
                        cmpl_len_q <= {beat_cnt[LEN_BITS-OFF_BITS-1:0], {OFF_BITS{1'b0}}}
                                      + LEN_BITS'(popcount(out_keep));
                        if (at_last) begin
                            if (s_axis_tlast) begin
                                cmpl_err_q <= 1'b0;
                                state      <= CMPL;
                            end else begin
                                cmpl_err_q <= 1'b1;
                                cnt_long_q <= cnt_long_q + 32'd1;
                                state      <= DRAIN;
                            end
                        end else if (s_axis_tlast) begin
                            cmpl_err_q  <= 1'b1;
                            cnt_short_q <= cnt_short_q + 32'd1;
                            state       <= CMPL;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_last) state <= CMPL;
                end
                CMPL: begin
                    if (m_cmpl_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_req_ready  = req_ready_q;
    assign m_cmd_valid  = (state == CMD);
    assign m_cmd_vaddr  = cur_vaddr;
    assign m_cmd_len    = cur_len;
    assign m_cmd_host   = cur_host;
    assign m_cmpl_valid = (state == CMPL);
    assign m_cmpl_pid   = cur_pid;
    assign m_cmpl_vfid  = cur_vfid;
    assign m_cmpl_len   = cmpl_len_q;
    assign m_cmpl_err   = cmpl_err_q;
    assign cnt_short    = cnt_short_q;
    assign cnt_long     = cnt_long_q;

endmodule
